// File: rtl/scp_lsu.sv
// Load/store unit: decodes RV32I load/store width, drives a req/ready data-memory
// port and returns sign/zero-extended load data, stalling the core while busy.
module scp_lsu #(
    parameter int X_LEN = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             req_valid_i,
    input  logic             req_we_i,
    input  logic [2:0]       req_funct3_i,
    input  logic [X_LEN-1:0] req_addr_i,
    input  logic [X_LEN-1:0] req_wdata_i,
    output logic             stall_o,
    output logic             rsp_valid_o,
    output logic [X_LEN-1:0] rsp_rdata_o,
    output logic             err_o,
    output logic             mem_req_o,
    output logic             mem_we_o,
    output logic [X_LEN-1:0] mem_addr_o,
    output logic [3:0]       mem_be_o,
    output logic [X_LEN-1:0] mem_wdata_o,
    input  logic [X_LEN-1:0] mem_rdata_i,
    input  logic             mem_ready_i
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

    state_e             state_q, state_d;
    logic               mem_req_q, mem_req_d;
    logic               mem_we_q, mem_we_d;
    logic [X_LEN-1:0]   mem_addr_q, mem_addr_d;
    logic [3:0]         mem_be_q, mem_be_d;
    logic [X_LEN-1:0]   mem_wdata_q, mem_wdata_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic [X_LEN-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic               err_q, err_d;
    logic [2:0]         funct3_q, funct3_d;
    logic [1:0]         off_q, off_d;

    logic [1:0]         req_off;
    logic               req_err;
    logic [3:0]         req_be;
    logic [X_LEN-1:0]   req_wdata;
    logic [X_LEN-1:0]   shifted;
    logic [X_LEN-1:0]   load_data;

    // Request decode: byte enables, lane replication and alignment/funct3 legality
    always_comb begin
        req_off = req_addr_i[1:0];
        case (req_funct3_i[1:0])
            2'b00: begin
                req_be    = 4'b0001 << req_off;
                req_wdata = {4{req_wdata_i[7:0]}};
            end
            2'b01: begin
                req_be    = 4'b0011 << req_off;
                req_wdata = {2{req_wdata_i[15:0]}};
            end
            default: begin
                req_be    = 4'hF;
                req_wdata = req_wdata_i;
            end
        endcase
        req_err = (req_we_i ? (req_funct3_i >= 3'b011)
                            : (req_funct3_i == 3'b011 || req_funct3_i >= 3'b110))
                | (req_funct3_i[1:0] == 2'b01 && req_off[0])
                | (req_funct3_i[1:0] == 2'b10 && req_off != 2'b00);
    end

    always_comb begin
        shifted = mem_rdata_i >> {off_q, 3'b000};
        case (funct3_q)
            3'b000:  load_data = {{24{shifted[7]}}, shifted[7:0]};
            3'b001:  load_data = {{16{shifted[15]}}, shifted[15:0]};
            3'b010:  load_data = shifted;
            3'b100:  load_data = {24'b0, shifted[7:0]};
            3'b101:  load_data = {16'b0, shifted[15:0]};
            default: load_data = '0;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_be_d    = mem_be_q;
        mem_wdata_d = mem_wdata_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = '0;
        err_d       = 1'b0;
        funct3_d    = funct3_q;
        off_d       = off_q;
        case (state_q)
            IDLE: begin
                if (req_valid_i) begin
                    if (req_err) begin
                        rsp_valid_d = 1'b1;
                        err_d       = 1'b1;
                        state_d     = DONE;
                    end else begin
                        mem_req_d   = 1'b1;
                        mem_we_d    = req_we_i;
                        mem_addr_d  = {req_addr_i[X_LEN-1:2], 2'b00};
                        mem_be_d    = req_be;
                        mem_wdata_d = req_wdata;
                        funct3_d    = req_funct3_i;
                        off_d       = req_off;
                        state_d     = BUSY;
                    end
                end
            end
            BUSY: begin
                if (mem_ready_i) begin
                    mem_req_d   = 1'b0;
                    mem_we_d    = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = mem_we_q ? '0 : load_data;
                    state_d     = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_be_q    <= '0;
            mem_wdata_q <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            err_q       <= 1'b0;
            funct3_q    <= '0;
            off_q       <= '0;
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_be_q    <= mem_be_d;
            mem_wdata_q <= mem_wdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            err_q       <= err_d;
            funct3_q    <= funct3_d;
            off_q       <= off_d;
        end
    end

    // The core is held only while a request is being accepted or the bus is busy
    assign stall_o     = (state_q == IDLE && req_valid_i) || (state_q == BUSY);
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_rdata_o = rsp_rdata_q;
    assign err_o       = err_q;
    assign mem_req_o   = mem_req_q;
    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_be_o    = mem_be_q;
    assign mem_wdata_o = mem_wdata_q;

endmodule
